// File: rtl/output_arbiter.sv
// Per-output wormhole arbiter: round-robin header arbitration, HEADER..TAIL lock,
// ack steering back to the winner, and a sticky stall watchdog.
module output_arbiter #(
  parameter int PORTS   = 4,
  parameter int TIMEOUT = 0,
  parameter int CW      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORTS-1:0]         req,
  input  logic [PORTS-1:0]         valid,
  input  logic [PORTS-1:0]         hdr,
  input  logic [PORTS-1:0]         tail,
  input  logic                     ack_down,
  output logic [PORTS-1:0]         grant,
  output logic [$clog2(PORTS)-1:0] grant_idx,
  output logic [PORTS-1:0]         ack_up,
  output logic                     locked,
  output logic                     stall_err
);

  localparam int IW = $clog2(PORTS);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]    r_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_owner;
  logic [CW-1:0] r_cnt;
  logic          r_stall;

  logic [PORTS-1:0] w_elig;
  logic [IW-1:0]    w_cand;
  logic [IW-1:0]    w_win_idx;
  logic             w_win_any;
  logic [IW-1:0]    w_sel_idx;
  logic             w_sel_any;
  logic [PORTS-1:0] w_onehot;
  logic             w_hdr_acc;
  logic             w_own_acc;
  logic             w_own_tail;
  logic [CW-1:0]    w_cnt_nxt;

  function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
    return IW'((int'(i) + 1) % PORTS);
  endfunction

  assign w_elig = req & valid & hdr;

  // Scan from the lowest priority upward so the first eligible input after ptr wins last.
  always_comb begin
    w_win_any = 1'b0;
    w_win_idx = {IW{1'b0}};
    w_cand    = {IW{1'b0}};
    for (int k = PORTS - 1; k >= 0; k--) begin
      w_cand    = IW'((int'(r_ptr) + k) % PORTS);
      w_win_idx = w_elig[w_cand] ? w_cand : w_win_idx;
      w_win_any = w_win_any | w_elig[w_cand];
    end
  end

  assign w_sel_idx  = (r_state == ST_LOCKED) ? r_owner : w_win_idx;
  assign w_sel_any  = (r_state == ST_LOCKED) | w_win_any;
  assign w_onehot   = {{(PORTS-1){1'b0}}, 1'b1} << w_sel_idx;
  assign w_hdr_acc  = (r_state == ST_IDLE) & w_win_any & ack_down;
  assign w_own_acc  = valid[r_owner] & ack_down;
  assign w_own_tail = w_own_acc & tail[r_owner];

  // Outputs are gated by rst so nothing leaks while the combinational IDLE path sees inputs.
  assign grant     = (w_sel_any && !rst) ? w_onehot : {PORTS{1'b0}};
  assign grant_idx = (w_sel_any && !rst) ? w_sel_idx : {IW{1'b0}};
  assign ack_up    = grant & {PORTS{ack_down}};
  assign locked    = (r_state == ST_LOCKED) && !rst;
  assign stall_err = r_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= {IW{1'b0}};
      r_owner <= {IW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hdr_acc) begin
            if (tail[w_win_idx]) begin
              r_ptr <= inc_idx(w_win_idx);
            end else begin
              r_state <= ST_LOCKED;
              r_owner <= w_win_idx;
            end
          end
        end
        ST_LOCKED: begin
          if (w_own_tail) begin
            r_state <= ST_IDLE;
            r_ptr   <= inc_idx(r_owner);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Watchdog counts idle cycles of a held lock; any accepted owner flit restarts it.
  always_comb begin
    w_cnt_nxt = {CW{1'b0}};
    if (TIMEOUT != 0 && r_state == ST_LOCKED && !w_own_acc) begin
      w_cnt_nxt = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      w_cnt_nxt = {CW{1'b0}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= {CW{1'b0}};
      r_stall <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (TIMEOUT != 0 && w_cnt_nxt == CW'(TIMEOUT)) begin
        r_stall <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
// Directed-vector bench for output_arbiter; the driver queues expected outputs per cycle
// and an independent negedge monitor pops and compares them.
module tb_output_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req, valid, hdr, tail;
  logic       ack_down;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic [3:0] ack_up;
  logic       locked;
  logic       stall_err;

  typedef struct {
    logic [3:0] g;
    logic [3:0] a;
    logic       l;
    logic       s;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic [3:0] oh;

  output_arbiter #(.PORTS(4), .TIMEOUT(5), .CW(16)) dut (
    .clk(clk), .rst(rst), .req(req), .valid(valid), .hdr(hdr), .tail(tail),
    .ack_down(ack_down), .grant(grant), .grant_idx(grant_idx), .ack_up(ack_up),
    .locked(locked), .stall_err(stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.nm, ".grant"}, grant, e.g);
      chk({e.nm, ".grant_idx"}, {2'b00, grant_idx}, {2'b00, idx_of(e.g)});
      chk({e.nm, ".ack_up"}, ack_up, e.a);
      chk({e.nm, ".locked"}, {3'b000, locked}, {3'b000, e.l});
      chk({e.nm, ".stall_err"}, {3'b000, stall_err}, {3'b000, e.s});
      chk({e.nm, ".onehot0"}, {3'b000, $onehot0(grant)}, 4'b0001);
      chk({e.nm, ".ack_subset"}, ack_up & ~grant, 4'b0000);
    end
  end

  task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] v,
                     input logic [3:0] h, input logic [3:0] t, input logic a,
                     input logic [3:0] eg, input logic el, input logic es, input string nm);
    exp_t e;
    rst = r; req = rq; valid = v; hdr = h; tail = t; ack_down = a;
    e.g = eg; e.a = eg & {4{a}}; e.l = el; e.s = es; e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0; valid = 4'b0; hdr = 4'b0; tail = 4'b0; ack_down = 1'b0;
    @(posedge clk);
    #1;
    // reset holds outputs low even with a live header
    cyc(1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, "rst");

    // test 1: single requester, 4-flit packet
    cyc(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, "t1_hdr");
    cyc(1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, "t1_body1");
    cyc(1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, "t1_body2");
    cyc(1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, "t1_tail");
    cyc(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, "t1_idle");
    // ptr=1: single-flit headers on 0 and 1 -> 1 wins, then single-flit on 3 -> ptr back to 0
    cyc(1'b0, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 1'b1, 4'b0010, 1'b0, 1'b0, "t1_ptr1");
    cyc(1'b0, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0, 1'b0, "t1_sf3");

    // test 2: inputs 1 and 3 contend with ptr=0
    cyc(1'b0, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0, "t2_hdr");
    cyc(1'b0, 4'b1010, 4'b1010, 4'b1000, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, "t2_body");
    cyc(1'b0, 4'b1010, 4'b1010, 4'b1000, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b0, "t2_tail");
    cyc(1'b0, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0, "t2_hdr3");
    cyc(1'b0, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1, 4'b1000, 1'b1, 1'b0, "t2_tail3");

    // test 3: all inputs stream 3-flit packets, grant order 0,1,2,3,0
    for (int p = 0; p < 5; p++) begin
      oh = 4'b0001 << (p % 4);
      cyc(1'b0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b1, oh, 1'b0, 1'b0, "t3_hdr");
      cyc(1'b0, 4'b1111, 4'b1111, ~oh, 4'b0000, 1'b1, oh, 1'b1, 1'b0, "t3_body");
      cyc(1'b0, 4'b1111, 4'b1111, ~oh, oh, 1'b1, oh, 1'b1, 1'b0, "t3_tail");
    end

    // test 4: lock on 2 (ptr=1), owner header as data, tail held off by ack_down
    cyc(1'b0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0, "t4_hdr");
    cyc(1'b0, 4'b0101, 4'b0101, 4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0, "t4_ownhdr");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, "t4_tail_wait");
    cyc(1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0, "t4_tail");
    cyc(1'b0, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 1'b1, 4'b1000, 1'b0, 1'b0, "t4_ptr3");
    // header with ack_down low: no lock, no ptr move, winner follows req
    cyc(1'b0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0, "t4_noack1");
    cyc(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, "t4_noack0");
    cyc(1'b0, 4'b0011, 4'b0011, 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, "t4_noack01");

    // test 5: watchdog with TIMEOUT=5
    cyc(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, "t5_hdr");
    for (int i = 1; i <= 6; i++)
      cyc(1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b1, (i == 6), "t5_stall");
    cyc(1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b1, "t5_body");
    cyc(1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, "t5_tail");
    cyc(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, "t5_idle");

    // test 6: reset mid-packet (ptr=1 before reset)
    cyc(1'b0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b1, "t6_hdr");
    cyc(1'b0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b1, "t6_body");
    cyc(1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, "t6_rst");
    cyc(1'b0, 4'b1001, 4'b1001, 4'b1001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, "t6_ptr0");
    cyc(1'b0, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0, 1'b0, "t6_hdr3");
    cyc(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, "t6_idle");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    #2;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
